// File: rtl/sextium_io_fifo_slave_pkg.sv
// Shared constants for the Sextium I/O FIFO path (also used by the I/O master).
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sextium_io_fifo_slave_pkg;

  // Width of one Sextium I/O word.
  localparam int SEXTIUM_IO_WIDTH = 16;

  // Default byte addresses of the FIFO ports on the Avalon bus.
  localparam logic [31:0] READ_FIFO_ADDR_DEFAULT  = 32'h0002_1000;
  localparam logic [31:0] WRITE_FIFO_ADDR_DEFAULT = 32'h0002_2000;

  // Default FIFO depth exponent (16 entries).
  localparam int DEPTH_LOG2_DEFAULT = 4;

endpackage

// File: rtl/sextium_io_fifo_slave_if.sv
// Avalon-MM slave bus plus host stream signals of the I/O FIFO slave.
// Latency: n/a (wiring only).
// Backpressure: waitrequest on the CPU side, valid/ready on the host side.
interface sextium_io_fifo_slave_if
  import sextium_io_fifo_slave_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
);

  // Avalon-MM side
  logic [31:0]                   address;
  logic                          read;
  logic [31:0]                   readdata;
  logic                          waitrequest;
  logic                          write;
  logic [31:0]                   writedata;
  logic [3:0]                    byteenable;

  // Host stream toward the CPU
  logic [SEXTIUM_IO_WIDTH-1:0]   in_data;
  logic                          in_valid;
  logic                          in_ready;

  // Host stream from the CPU
  logic [SEXTIUM_IO_WIDTH-1:0]   out_data;
  logic                          out_valid;
  logic                          out_ready;

  // Occupancy
  logic [DEPTH_LOG2:0]           in_count;
  logic [DEPTH_LOG2:0]           out_count;

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest,
    input  in_data, in_valid,
    output in_ready,
    output out_data, out_valid,
    input  out_ready,
    output in_count, out_count
  );

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest,
    output in_data, in_valid,
    input  in_ready,
    input  out_data, out_valid,
    output out_ready,
    input  in_count, out_count
  );

endinterface

// File: rtl/sextium_io_fifo_slave_sync_fifo.sv
// Single-clock FIFO with combinational head output and occupancy count.
// Latency: a word pushed at edge N is at the head (empty=0) right after edge N.
// Backpressure: push ignored when full, pop ignored when empty; full blocks push even with a pop.
module sextium_sync_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next-state pointers and count; pointers wrap naturally at DEPTH.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
    if (do_push) wptr_d = wptr_q + DEPTH_LOG2'(1);
    if (do_pop)  rptr_d = rptr_q + DEPTH_LOG2'(1);
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/sextium_io_fifo_slave.sv
// Avalon-MM slave terminating CPU FIFO-mode I/O: pops input FIFO on reads, pushes output FIFO on writes.
// Latency: zero beyond the waitrequest cycle; host word pushed at edge N is readable after edge N.
// Backpressure: waitrequest stalls on empty/full FIFO; host side uses valid/ready.
module sextium_io_fifo_slave
  import sextium_io_fifo_slave_pkg::*;
#(
  parameter logic [31:0] READ_FIFO_ADDR  = READ_FIFO_ADDR_DEFAULT,
  parameter logic [31:0] WRITE_FIFO_ADDR = WRITE_FIFO_ADDR_DEFAULT,
  parameter int          DEPTH_LOG2      = DEPTH_LOG2_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  sextium_io_fifo_slave_if.slave   bus
);

  logic                        rd_fifo, wr_fifo;
  logic                        in_push, in_pop, in_full, in_empty;
  logic                        out_push, out_pop, out_full, out_empty;
  logic [SEXTIUM_IO_WIDTH-1:0] in_head;
  logic                        unused_bits;

  // Upper write bits and byte enables carry no information for 16-bit I/O.
  assign unused_bits = ^{bus.writedata[31:SEXTIUM_IO_WIDTH], bus.byteenable};

  // Address decode and stall; a read always takes priority over a write.
  always_comb begin
    rd_fifo = bus.read & (bus.address == READ_FIFO_ADDR);
    wr_fifo = bus.write & ~bus.read & (bus.address == WRITE_FIFO_ADDR);
    if (reset) begin
      bus.waitrequest = bus.read | bus.write;
    end else begin
      bus.waitrequest = (rd_fifo & in_empty) | (wr_fifo & out_full);
    end
    bus.readdata = '0;
    if (rd_fifo && !in_empty) begin
      bus.readdata = {{(32 - SEXTIUM_IO_WIDTH){1'b0}}, in_head};
    end
  end

  assign bus.in_ready  = ~reset & ~in_full;
  assign bus.out_valid = ~reset & ~out_empty;

  assign in_push  = bus.in_valid & bus.in_ready;
  assign in_pop   = rd_fifo & ~bus.waitrequest;
  assign out_push = wr_fifo & ~bus.waitrequest;
  assign out_pop  = bus.out_valid & bus.out_ready;

  sextium_sync_fifo #(
    .WIDTH      (SEXTIUM_IO_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_in_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (in_push),
    .pop   (in_pop),
    .wdata (bus.in_data),
    .rdata (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (bus.in_count)
  );

  sextium_sync_fifo #(
    .WIDTH      (SEXTIUM_IO_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (out_push),
    .pop   (out_pop),
    .wdata (bus.writedata[SEXTIUM_IO_WIDTH-1:0]),
    .rdata (bus.out_data),
    .full  (out_full),
    .empty (out_empty),
    .count (bus.out_count)
  );

endmodule

// File: tb/tb_sextium_io_fifo_slave.sv
// Directed bench for sextium_io_fifo_slave with scoreboard queues for both FIFOs.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
// Stalls are bounded by cycle budgets; an expired budget counts as a failed check.
module tb_sextium_io_fifo_slave;
  import sextium_io_fifo_slave_pkg::*;

  localparam logic [31:0] RD_A = READ_FIFO_ADDR_DEFAULT;
  localparam logic [31:0] WR_A = WRITE_FIFO_ADDR_DEFAULT;

  logic clk;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic [15:0] exp_in_q[$];   // words expected from CPU reads of the input FIFO
  logic [15:0] exp_out_q[$];  // words expected on the host output stream

  sextium_io_fifo_slave_if #(.DEPTH_LOG2(4)) bus ();

  sextium_io_fifo_slave #(
    .READ_FIFO_ADDR  (RD_A),
    .WRITE_FIFO_ADDR (WR_A),
    .DEPTH_LOG2      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // CPU read; expected data comes from the scoreboard at completion time.
  task automatic cpu_read(input logic [31:0] addr, input int budget);
    bit done = 0;
    logic [31:0] exp;
    @(posedge clk); #1;
    bus.address = addr; bus.read = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (bus.waitrequest === 1'b0) begin
        if (addr == RD_A) exp = (exp_in_q.size() > 0) ? {16'h0, exp_in_q.pop_front()} : 32'hDEAD_DEAD;
        else              exp = 32'h0;
        chk("rd_data", bus.readdata, exp);
        done = 1;
      end
    end
    if (!done) chk("rd_timeout_waitrequest", {31'h0, bus.waitrequest}, 32'h0);
    @(posedge clk); #1;
    bus.read = 1'b0;
  endtask

  // CPU write; scoreboard records the word when the transfer completes.
  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data, input int budget);
    bit done = 0;
    @(posedge clk); #1;
    bus.address = addr; bus.write = 1'b1; bus.writedata = data;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (bus.waitrequest === 1'b0) begin
        if (addr == WR_A) exp_out_q.push_back(data[15:0]);
        done = 1;
      end
    end
    if (!done) chk("wr_timeout_waitrequest", {31'h0, bus.waitrequest}, 32'h0);
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  // One host word offered for a single cycle.
  task automatic host_push(input logic [15:0] d, input bit expect_accept);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = d;
    @(negedge clk);
    chk("in_ready", {31'h0, bus.in_ready}, {31'h0, expect_accept});
    if (expect_accept) exp_in_q.push_back(d);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // One host pop, checked against the output scoreboard.
  task automatic host_pop();
    logic [15:0] exp;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    exp = (exp_out_q.size() > 0) ? exp_out_q.pop_front() : 16'hDEAD;
    chk("out_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("out_data", {16'h0, bus.out_data}, {16'h0, exp});
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.address = '0; bus.read = 0; bus.write = 0; bus.writedata = '0;
    bus.byteenable = 4'hF; bus.in_data = '0; bus.in_valid = 0; bus.out_ready = 0;
    reset = 1'b1;
    #2;
    bus.read = 1'b1; bus.address = 32'h0000_1234;
    #1;
    chk("rst_waitrequest", {31'h0, bus.waitrequest}, 32'h1);
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    bus.read = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("post_rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("post_rst_in_count", {27'h0, bus.in_count}, 32'h0);
    chk("post_rst_out_count", {27'h0, bus.out_count}, 32'h0);
    chk("idle_waitrequest", {31'h0, bus.waitrequest}, 32'h0);

    // Read stalls on empty input FIFO until the host supplies a word.
    fork
      cpu_read(RD_A, 30);
      begin
        repeat (4) @(negedge clk);
        chk("stall_empty_waitrequest", {31'h0, bus.waitrequest}, 32'h1);
        host_push(16'hBEEF, 1'b1);
      end
    join
    @(negedge clk);
    chk("in_count_after_read", {27'h0, bus.in_count}, 32'h0);

    // Fill input FIFO; 17th word refused; drain in order.
    for (int i = 0; i < 16; i++) host_push(16'(i), 1'b1);
    @(negedge clk);
    chk("in_count_full", {27'h0, bus.in_count}, 32'd16);
    host_push(16'h00AA, 1'b0);
    chk("in_count_still_full", {27'h0, bus.in_count}, 32'd16);
    for (int i = 0; i < 16; i++) cpu_read(RD_A, 5);
    @(negedge clk);
    chk("in_count_drained", {27'h0, bus.in_count}, 32'h0);

    // CPU writes held in output FIFO, upper write bits discarded.
    cpu_write(WR_A, 32'h0000_1234, 5);
    cpu_write(WR_A, 32'hFFFF_5678, 5);
    @(negedge clk);
    chk("out_count_2", {27'h0, bus.out_count}, 32'd2);
    chk("out_head_1234", {16'h0, bus.out_data}, 32'h0000_1234);
    host_pop();
    host_pop();
    @(negedge clk);
    chk("out_valid_empty", {31'h0, bus.out_valid}, 32'h0);

    // Full output FIFO stalls a write until the host frees a slot.
    for (int i = 0; i < 16; i++) cpu_write(WR_A, 32'h0000_A000 + 32'(i), 5);
    @(negedge clk);
    chk("out_count_full", {27'h0, bus.out_count}, 32'd16);
    fork
      cpu_write(WR_A, 32'h0000_C0DE, 30);
      begin
        repeat (4) @(negedge clk);
        chk("stall_full_waitrequest", {31'h0, bus.waitrequest}, 32'h1);
        host_pop();
      end
    join
    @(negedge clk);
    chk("out_count_refull", {27'h0, bus.out_count}, 32'd16);
    for (int i = 0; i < 16; i++) host_pop();
    @(negedge clk);
    chk("out_empty_again", {31'h0, bus.out_valid}, 32'h0);

    // Read and write together: read wins, write ignored.
    host_push(16'h0007, 1'b1);
    @(posedge clk); #1;
    bus.address = RD_A; bus.read = 1'b1; bus.write = 1'b1; bus.writedata = 32'h0000_9999;
    @(negedge clk);
    chk("rw_waitrequest", {31'h0, bus.waitrequest}, 32'h0);
    chk("rw_readdata", bus.readdata, {16'h0, exp_in_q.pop_front()});
    @(posedge clk); #1;
    bus.address = WR_A;
    @(negedge clk);
    chk("rw_wraddr_readdata", bus.readdata, 32'h0);
    chk("rw_wraddr_waitrequest", {31'h0, bus.waitrequest}, 32'h0);
    @(posedge clk); #1;
    bus.read = 1'b0; bus.write = 1'b0;
    @(negedge clk);
    chk("rw_out_count", {27'h0, bus.out_count}, 32'h0);
    chk("rw_in_count", {27'h0, bus.in_count}, 32'h0);

    // Unmapped read completes immediately with zero.
    cpu_read(32'h0002_0005, 2);

    // Reset during a stalled read with words in the output FIFO.
    for (int i = 0; i < 3; i++) cpu_write(WR_A, 32'h0000_0100 + 32'(i), 5);
    fork
      cpu_read(RD_A, 40);
      begin
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("midrst_out_count", {27'h0, bus.out_count}, 32'h0);
        chk("midrst_in_count", {27'h0, bus.in_count}, 32'h0);
        chk("midrst_waitrequest", {31'h0, bus.waitrequest}, 32'h1);
        exp_out_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("postrst_stall", {31'h0, bus.waitrequest}, 32'h1);
        host_push(16'h0055, 1'b1);
      end
    join
    @(negedge clk);
    chk("final_out_valid", {31'h0, bus.out_valid}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
